// File: rtl/sys_ver_div.sv
// rtl/sys_ver_div.sv - iterative restoring divider, 2P-bit dividend by P-bit divisor
// One quotient bit per clock; divide-by-zero and quotient overflow caught before iterating.
module sys_ver_div #(
  parameter int P = 8
) (
  input  logic           C,
  input  logic           RST_n,
  input  logic           START,
  input  logic [2*P-1:0] DATA_IN,
  input  logic [P-1:0]   DIV_IN,
  output logic           BUSY,
  output logic           VALID,
  output logic [P-1:0]   Q_OUT,
  output logic [P-1:0]   R_OUT,
  output logic [1:0]     ERR
);

  localparam int CW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_CALC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [2*P-1:0] dvd_q, dvd_d;
  logic [P-1:0]   dvs_q, dvs_d;
  logic [P-1:0]   rem_q, rem_d;
  logic [P-1:0]   shf_q, shf_d;
  logic [P-1:0]   quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [P-1:0]   q_out_q, q_out_d;
  logic [P-1:0]   r_out_q, r_out_d;
  logic [1:0]     err_q, err_d;

  logic [P:0]     trial;
  logic           qbit;
  logic [P-1:0]   rem_next;
  logic [P-1:0]   quo_next;

  always_ff @(posedge C or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      shf_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      shf_q   <= shf_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      err_q   <= err_d;
    end
  end

  // One restoring step; the overflow check keeps the difference within P bits.
  always_comb begin
    trial    = {rem_q, shf_q[P-1]};
    qbit     = (trial >= {1'b0, dvs_q});
    rem_next = qbit ? (trial[P-1:0] - dvs_q) : trial[P-1:0];
    quo_next = {quo_q[P-2:0], qbit};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    shf_d   = shf_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          dvd_d   = DATA_IN;
          dvs_d   = DIV_IN;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (dvs_q == '0) begin
          err_d   = 2'b01;
          q_out_d = '0;
          r_out_d = '0;
          state_d = S_DONE;
        end else if (dvd_q[2*P-1:P] >= dvs_q) begin
          err_d   = 2'b10;
          q_out_d = '0;
          r_out_d = '0;
          state_d = S_DONE;
        end else begin
          rem_d   = dvd_q[2*P-1:P];
          shf_d   = dvd_q[P-1:0];
          quo_d   = '0;
          cnt_d   = CW'(P - 1);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = rem_next;
        quo_d = quo_next;
        shf_d = {shf_q[P-2:0], 1'b0};
        if (cnt_q == '0) begin
          q_out_d = quo_next;
          r_out_d = rem_next;
          err_d   = 2'b00;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign BUSY  = (state_q != S_IDLE);
  assign VALID = (state_q == S_DONE);
  assign Q_OUT = q_out_q;
  assign R_OUT = r_out_q;
  assign ERR   = err_q;

endmodule
